// File: rtl/loader_pkg.sv
// Shared command codes, reply bytes and FSM state encoding for the UART program loader.
// LOADER_CHECKSUM_EN adds the CHECK state used to verify a trailing XOR checksum byte.
package loader_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_HALT = 8'h48;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GET_LEN,
    ST_GET_BYTE,
    ST_WRITE,
`ifdef LOADER_CHECKSUM_EN
    ST_CHECK,
`endif
    ST_SEND_WR,
    ST_SEND_START,
    ST_SEND_WAIT,
    ST_RUN
  } loader_state_t;

endpackage

// File: rtl/loader_word_asm.sv
// Little-endian word assembler: shifts received bytes in from the top so the first
// byte ends up in the least significant lane, and pulses o_word_valid once a word is complete.
module loader_word_asm #(
  parameter int NB_UART_DATA   = 8,
  parameter int NB_INSTRUCTION = 32
) (
  input  logic                      clk,
  input  logic                      i_rst,
  input  logic                      i_clear,
  input  logic                      i_byte_valid,
  input  logic [NB_UART_DATA-1:0]   i_byte,
  output logic                      o_last_byte,
  output logic [NB_INSTRUCTION-1:0] o_word,
  output logic                      o_word_valid
);

  localparam int BYTES = NB_INSTRUCTION / NB_UART_DATA;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [CNT_W-1:0] byte_cnt;

  assign o_last_byte = (byte_cnt == CNT_W'(BYTES - 1));

  always_ff @(posedge clk) begin
    if (i_rst) begin
      byte_cnt     <= '0;
      o_word       <= '0;
      o_word_valid <= 1'b0;
    end else begin
      o_word_valid <= i_byte_valid && o_last_byte;
      if (i_clear) begin
        byte_cnt <= '0;
      end else if (i_byte_valid) begin
        o_word   <= {i_byte, o_word[NB_INSTRUCTION-1:NB_UART_DATA]};
        byte_cnt <= o_last_byte ? '0 : byte_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_loader.sv
// UART boot loader: parses L/R/H commands from the rx FIFO, writes instruction memory and
// replies ACK/NAK over tx. Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module uart_loader
  import loader_pkg::*;
#(
  parameter int NB_UART_DATA    = 8,
  parameter int NB_INSTRUCTION  = 32,
  parameter int IMEM_ADDR_WIDTH = 7
) (
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic [NB_UART_DATA-1:0]    i_uart_rx_data,
  input  logic                       i_uart_rx_done,
  output logic                       o_uart_rd,
  output logic [NB_UART_DATA-1:0]    o_uart_wdata,
  output logic                       o_uart_wr,
  output logic                       o_uart_tx_start,
  input  logic                       i_uart_tx_done,
  output logic                       o_imem_we,
  output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
  output logic [NB_INSTRUCTION-1:0]  o_imem_wdata,
  output logic                       o_cpu_en
);

  localparam int DEPTH = 1 << IMEM_ADDR_WIDTH;
  localparam logic [NB_UART_DATA-1:0] LOAD = NB_UART_DATA'(CMD_LOAD);
  localparam logic [NB_UART_DATA-1:0] RUN  = NB_UART_DATA'(CMD_RUN);
  localparam logic [NB_UART_DATA-1:0] HALT = NB_UART_DATA'(CMD_HALT);
  localparam logic [NB_UART_DATA-1:0] ACK  = NB_UART_DATA'(ACK_BYTE);
  localparam logic [NB_UART_DATA-1:0] NAK  = NB_UART_DATA'(NAK_BYTE);

  loader_state_t state;
  loader_state_t next_q;
  logic [NB_UART_DATA-1:0]   len_q;
  logic                      rx_take;
  logic                      last_word;
  logic                      asm_clear;
  logic                      asm_byte_valid;
  logic                      asm_last_byte;
  logic                      asm_word_valid;
  logic [NB_INSTRUCTION-1:0] asm_word;
`ifdef LOADER_CHECKSUM_EN
  logic [NB_UART_DATA-1:0]   xor_q;
`endif

  // The rx FIFO head stays valid during the pop cycle, so it must not be taken twice.
  assign rx_take        = i_uart_rx_done && !o_uart_rd;
  assign asm_clear      = (state == ST_GET_LEN) && rx_take;
  assign asm_byte_valid = (state == ST_GET_BYTE) && rx_take;
  assign last_word      = (int'(o_imem_addr) + 1) == int'(len_q);

  // The write strobe is the assembler's registered valid, which only fires on entry to WRITE.
  assign o_imem_we    = asm_word_valid;
  assign o_imem_wdata = asm_word;

  loader_word_asm #(
    .NB_UART_DATA   (NB_UART_DATA),
    .NB_INSTRUCTION (NB_INSTRUCTION)
  ) u_word_asm (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_clear      (asm_clear),
    .i_byte_valid (asm_byte_valid),
    .i_byte       (i_uart_rx_data),
    .o_last_byte  (asm_last_byte),
    .o_word       (asm_word),
    .o_word_valid (asm_word_valid)
  );

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state           <= ST_IDLE;
      next_q          <= ST_IDLE;
      len_q           <= '0;
      o_uart_rd       <= 1'b0;
      o_uart_wr       <= 1'b0;
      o_uart_tx_start <= 1'b0;
      o_uart_wdata    <= '0;
      o_imem_addr     <= '0;
      o_cpu_en        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_q           <= '0;
`endif
    end else begin
      o_uart_rd       <= 1'b0;
      o_uart_wr       <= 1'b0;
      o_uart_tx_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_take) begin
            o_uart_rd <= 1'b1;
            if (i_uart_rx_data == LOAD) begin
              state <= ST_GET_LEN;
            end else begin
              state     <= ST_SEND_WR;
              o_uart_wr <= 1'b1;
              if (i_uart_rx_data == RUN) begin
                o_uart_wdata <= ACK;
                next_q       <= ST_RUN;
              end else begin
                o_uart_wdata <= NAK;
                next_q       <= ST_IDLE;
              end
            end
          end
        end
        ST_GET_LEN: begin
          if (rx_take) begin
            o_uart_rd   <= 1'b1;
            len_q       <= i_uart_rx_data;
            o_imem_addr <= '0;
`ifdef LOADER_CHECKSUM_EN
            xor_q       <= '0;
`endif
            if (i_uart_rx_data == '0) begin
`ifdef LOADER_CHECKSUM_EN
              state <= ST_CHECK;
`else
              state        <= ST_SEND_WR;
              o_uart_wr    <= 1'b1;
              o_uart_wdata <= ACK;
              next_q       <= ST_IDLE;
`endif
            end else if (int'(i_uart_rx_data) > DEPTH) begin
              state        <= ST_SEND_WR;
              o_uart_wr    <= 1'b1;
              o_uart_wdata <= NAK;
              next_q       <= ST_IDLE;
            end else begin
              state <= ST_GET_BYTE;
            end
          end
        end
        ST_GET_BYTE: begin
          if (rx_take) begin
            o_uart_rd <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            xor_q     <= xor_q ^ i_uart_rx_data;
`endif
            if (asm_last_byte) state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          o_imem_addr <= o_imem_addr + IMEM_ADDR_WIDTH'(1);
          if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
            state <= ST_CHECK;
`else
            state        <= ST_SEND_WR;
            o_uart_wr    <= 1'b1;
            o_uart_wdata <= ACK;
            next_q       <= ST_IDLE;
`endif
          end else begin
            state <= ST_GET_BYTE;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (rx_take) begin
            o_uart_rd    <= 1'b1;
            state        <= ST_SEND_WR;
            o_uart_wr    <= 1'b1;
            o_uart_wdata <= (i_uart_rx_data == xor_q) ? ACK : NAK;
            next_q       <= ST_IDLE;
          end
        end
`endif
        ST_SEND_WR: begin
          state           <= ST_SEND_START;
          o_uart_tx_start <= 1'b1;
        end
        ST_SEND_START: begin
          state <= ST_SEND_WAIT;
        end
        ST_SEND_WAIT: begin
          if (i_uart_tx_done) begin
            state    <= next_q;
            o_cpu_en <= (next_q == ST_RUN);
          end
        end
        ST_RUN: begin
          if (rx_take) begin
            o_uart_rd <= 1'b1;
            if (i_uart_rx_data == HALT) begin
              o_cpu_en     <= 1'b0;
              state        <= ST_SEND_WR;
              o_uart_wr    <= 1'b1;
              o_uart_wdata <= ACK;
              next_q       <= ST_IDLE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_loader.md
UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 Parameter NB_UART_DATA, default 8: UART byte width.
REQ-002 Parameter NB_INSTRUCTION, default 32: instruction word width, 4 bytes.
REQ-003 Parameter IMEM_ADDR_WIDTH, default 7: instruction-memory word address width, so the depth is 2^IMEM_ADDR_WIDTH.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 i_rst  in  1  synchronous, active-high reset.
REQ-006 i_uart_rx_data  in  NB_UART_DATA  head byte of the UART rx FIFO.
REQ-007 i_uart_rx_done  in  1  high while a byte is available on i_uart_rx_data.
REQ-008 o_uart_rd  out  1  one-cycle pulse that pops the rx FIFO.
REQ-009 o_uart_wdata  out  NB_UART_DATA  byte to transmit.
REQ-010 o_uart_wr  out  1  one-cycle pulse that pushes o_uart_wdata into the tx FIFO.
REQ-011 o_uart_tx_start  out  1  one-cycle pulse that starts transmission.
REQ-012 i_uart_tx_done  in  1  transmission complete.
REQ-013 o_imem_we  out  1  instruction-memory write strobe.
REQ-014 o_imem_addr  out  IMEM_ADDR_WIDTH  instruction-memory word address.
REQ-015 o_imem_wdata  out  NB_INSTRUCTION  assembled instruction word.
REQ-016 o_cpu_en  out  1  CPU run enable; the CPU is halted while low.

Function
REQ-017 The FSM SHALL have states IDLE, GET_LEN, GET_BYTE, WRITE, CHECK (macro only), SEND_WR, SEND_START, SEND_WAIT and RUN.
REQ-018 Byte capture SHALL be defined as follows:
- In a receive state (IDLE, GET_LEN, GET_BYTE, RUN), a byte is captured on the edge where i_uart_rx_done=1.
- o_uart_rd SHALL be high for exactly the following cycle.
- i_uart_rx_done SHALL be ignored during that cycle.
REQ-019 In IDLE, commands SHALL be handled as follows:
- 0x4C ('L') -> GET_LEN.
- 0x52 ('R') -> transmit ACK 0x06, then RUN.
- Any other byte -> transmit NAK 0x15, then IDLE.
REQ-020 In GET_LEN, the length byte N SHALL be handled as follows:
- N=0 -> transmit ACK, no writes.
- N>2^IMEM_ADDR_WIDTH -> transmit NAK, return to IDLE; any later payload bytes are parsed as commands.
- Otherwise clear the address and byte counters and go to GET_BYTE.
REQ-021 Words SHALL be assembled little-endian: the first byte goes to bits [7:0] and the fourth to bits [31:24].
REQ-022 On the fourth byte the FSM SHALL enter WRITE and assert o_imem_we for one cycle, starting one cycle after that capture, with o_imem_addr = word index and o_imem_wdata = the word.
REQ-023 After WRITE, the address counter SHALL increment; the counter never wraps because N is bounded.
REQ-024 After the Nth write, the FSM SHALL go to transmit ACK; otherwise it returns to GET_BYTE.
REQ-025 Transmission SHALL take three steps:
- SEND_WR: o_uart_wr=1 with o_uart_wdata valid, for one cycle.
- SEND_START: o_uart_tx_start=1, for one cycle.
- SEND_WAIT: hold until i_uart_tx_done=1, then go to the pending next state.
REQ-026 o_cpu_en SHALL be 1 only in RUN.
REQ-027 In RUN, byte 0x48 ('H') SHALL clear o_cpu_en the next cycle and transmit ACK, then IDLE; other bytes are popped and discarded.
REQ-028 o_imem_we SHALL never be asserted outside WRITE.

Reset
REQ-029 While i_rst=1 on an edge, the state SHALL go to IDLE and all outputs SHALL be 0: o_uart_rd, o_uart_wr, o_uart_tx_start, o_imem_we, o_cpu_en, o_imem_addr, o_imem_wdata, o_uart_wdata.
REQ-030 Reset mid-load SHALL abandon the transfer; words already written stay in memory, and no ACK or NAK is sent.

Configuration
REQ-031 With macro LOADER_CHECKSUM_EN defined:
- One extra byte follows the 4N data bytes.
- CHECK compares it with the XOR of all data bytes: match -> ACK, mismatch -> NAK, and o_cpu_en stays 0.
- For N=0 the expected checksum is 0x00.
REQ-032 Without LOADER_CHECKSUM_EN, no checksum byte is expected and the CHECK state and XOR register SHALL not exist.

Structure
REQ-033 Package loader_pkg SHALL hold:
- the command codes 0x4C, 0x52 and 0x48;
- ACK 0x06 and NAK 0x15;
- the state encoding.
REQ-034 Sub-module loader_word_asm SHALL implement the byte counter and the little-endian shift register, with a word_valid output.

Verification
REQ-035 'L', 0x01, 0x13,0x00,0x00,0x00 -> one write at addr 0 with data 0x00000013, then tx byte 0x06.
REQ-036 'L', 0x02, 8 bytes 0x01..0x08 -> writes addr0=0x04030201 and addr1=0x08070605, then ACK.
REQ-037 'R' -> ACK, o_cpu_en=1; then 'H' -> o_cpu_en=0 and ACK.
REQ-038 Byte 0x00 in IDLE -> NAK 0x15; 'L', 0x81 -> NAK, no o_imem_we.
REQ-039 i_rst pulsed after 2 payload bytes -> all outputs 0, state IDLE, no tx; a following 'R' -> ACK.
REQ-040 With LOADER_CHECKSUM_EN: 'L',1,0x13,0,0,0,0x13 -> ACK; the same load with checksum 0x12 -> NAK.
